// File: rtl/conv_window_feeder_if.sv
// conv_window_feeder_if
//   Bundles the configuration, pixel stream and window output of the 3x3
//   window feeder.
//   master : drives cfg_width/cfg_height/in_valid/in_sof/in_pixel, observes outputs
//   slave  : the feeder; consumes the stream and drives out_valid/out_last/
//            out_window/frame_done/cfg_err
interface conv_window_feeder_if #(
  parameter int CH         = 18,
  parameter int DATA_WIDTH = 8,
  parameter int DIM_W      = 7
);
  logic [DIM_W-1:0]             cfg_width;
  logic [DIM_W-1:0]             cfg_height;
  logic                         in_valid;
  logic                         in_sof;
  logic [CH*DATA_WIDTH-1:0]     in_pixel;
  logic                         out_valid;
  logic                         out_last;
  logic [CH*9*DATA_WIDTH-1:0]   out_window;
  logic                         frame_done;
  logic                         cfg_err;

  modport master (
    output cfg_width, cfg_height, in_valid, in_sof, in_pixel,
    input  out_valid, out_last, out_window, frame_done, cfg_err
  );

  modport slave (
    input  cfg_width, cfg_height, in_valid, in_sof, in_pixel,
    output out_valid, out_last, out_window, frame_done, cfg_err
  );
endinterface

// File: rtl/conv_window_feeder.sv
// conv_window_feeder
//   Builds 3x3 sliding windows (no padding, stride 1) over a streamed feature
//   map for CH channels in parallel. Two line buffers per channel hold the two
//   previous rows; a 3x3 register window per channel shifts left on every
//   accepted pixel. Window byte k = 3*row + col, byte 8 is the newest pixel.
//   Ports:
//     clk  - clock
//     rstn - asynchronous active-low reset
//     bus  - slave side of conv_window_feeder_if (config, pixel stream, windows)
module conv_window_feeder #(
  parameter int CH         = 18,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 64,
  parameter int DIM_W      = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  conv_window_feeder_if.slave   bus
);

  localparam int PW = CH * DATA_WIDTH;
  localparam int WW = CH * 9 * DATA_WIDTH;
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [DIM_W-1:0] MIN_DIM = DIM_W'(3);
  localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(MAX_WIDTH);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [DIM_W-1:0] row_r, col_r, w_r, h_r;
  logic [DIM_W-1:0] row_nxt_s, col_nxt_s, w_nxt_s, h_nxt_s;
  logic [DIM_W-1:0] cur_row_s, cur_col_s, cur_w_s, cur_h_s;
  logic [PW-1:0]    lb0_r [MAX_WIDTH];
  logic [PW-1:0]    lb1_r [MAX_WIDTH];
  logic [PW-1:0]    top_s, mid_s;
  logic [AW-1:0]    lb_idx_s;
  logic [WW-1:0]    win_r, win_nxt_s;
  logic             out_valid_r, out_last_r, cfg_err_r;
  logic             out_valid_nxt_s, out_last_nxt_s, cfg_err_nxt_s;
  logic             start_s, cfg_ok_s, proc_s, last_s;

  // Decode the current pixel: a start-of-frame pixel is treated as (0,0) of a
  // new frame with freshly sampled dimensions, regardless of the state.
  always_comb begin
    start_s  = bus.in_valid & bus.in_sof;
    cfg_ok_s = (bus.cfg_width >= MIN_DIM) && (bus.cfg_width <= MAX_DIM) &&
               (bus.cfg_height >= MIN_DIM);
    if (start_s) begin
      cur_row_s = '0;
      cur_col_s = '0;
      cur_w_s   = bus.cfg_width;
      cur_h_s   = bus.cfg_height;
      proc_s    = cfg_ok_s;
    end else begin
      cur_row_s = row_r;
      cur_col_s = col_r;
      cur_w_s   = w_r;
      cur_h_s   = h_r;
      case (state_r)
        RUN:     proc_s = bus.in_valid;
        IDLE:    proc_s = 1'b0;
        default: proc_s = 1'b0;
      endcase
    end
    last_s   = (cur_row_s == cur_h_s - DIM_W'(1)) && (cur_col_s == cur_w_s - DIM_W'(1));
    lb_idx_s = cur_col_s[AW-1:0];
    top_s    = lb1_r[lb_idx_s];
    mid_s    = lb0_r[lb_idx_s];
  end

  // Next-state, counters, sticky config error and registered output strobes.
  always_comb begin
    state_nxt_s     = state_r;
    row_nxt_s       = row_r;
    col_nxt_s       = col_r;
    w_nxt_s         = w_r;
    h_nxt_s         = h_r;
    cfg_err_nxt_s   = cfg_err_r;
    out_valid_nxt_s = proc_s && (cur_row_s >= DIM_W'(2)) && (cur_col_s >= DIM_W'(2));
    out_last_nxt_s  = proc_s && last_s;
    if (proc_s) begin
      w_nxt_s = cur_w_s;
      h_nxt_s = cur_h_s;
      if (last_s) begin
        state_nxt_s = IDLE;
        row_nxt_s   = '0;
        col_nxt_s   = '0;
      end else if (cur_col_s == cur_w_s - DIM_W'(1)) begin
        state_nxt_s = RUN;
        row_nxt_s   = cur_row_s + DIM_W'(1);
        col_nxt_s   = '0;
      end else begin
        state_nxt_s = RUN;
        row_nxt_s   = cur_row_s;
        col_nxt_s   = cur_col_s + DIM_W'(1);
      end
    end else if (start_s) begin
      // Rejected dimensions: drop any frame in progress and wait for a new one.
      state_nxt_s   = IDLE;
      row_nxt_s     = '0;
      col_nxt_s     = '0;
      cfg_err_nxt_s = 1'b1;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Window shift: columns move left, new right column is {top, mid, pixel}.
  always_comb begin
    win_nxt_s = win_r;
    if (proc_s) begin
      for (int ch = 0; ch < CH; ch++) begin
        for (int r = 0; r < 3; r++) begin
          win_nxt_s[(ch*9 + 3*r    )*DATA_WIDTH +: DATA_WIDTH] = win_r[(ch*9 + 3*r + 1)*DATA_WIDTH +: DATA_WIDTH];
          win_nxt_s[(ch*9 + 3*r + 1)*DATA_WIDTH +: DATA_WIDTH] = win_r[(ch*9 + 3*r + 2)*DATA_WIDTH +: DATA_WIDTH];
        end
        win_nxt_s[(ch*9 + 2)*DATA_WIDTH +: DATA_WIDTH] = top_s[ch*DATA_WIDTH +: DATA_WIDTH];
        win_nxt_s[(ch*9 + 5)*DATA_WIDTH +: DATA_WIDTH] = mid_s[ch*DATA_WIDTH +: DATA_WIDTH];
        win_nxt_s[(ch*9 + 8)*DATA_WIDTH +: DATA_WIDTH] = bus.in_pixel[ch*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      win_nxt_s = win_r;
    end
  end

  // Control, window and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      row_r       <= '0;
      col_r       <= '0;
      w_r         <= '0;
      h_r         <= '0;
      win_r       <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      row_r       <= row_nxt_s;
      col_r       <= col_nxt_s;
      w_r         <= w_nxt_s;
      h_r         <= h_nxt_s;
      win_r       <= win_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_last_r  <= out_last_nxt_s;
      cfg_err_r   <= cfg_err_nxt_s;
    end
  end

  // Line buffers: lb1 ages out of lb0; read-before-write at the same column.
  always_ff @(posedge clk) begin
    if (proc_s) begin
      lb1_r[lb_idx_s] <= mid_s;
      lb0_r[lb_idx_s] <= bus.in_pixel;
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.out_last   = out_last_r;
  assign bus.frame_done = out_last_r;
  assign bus.out_window = win_r;
  assign bus.cfg_err    = cfg_err_r;

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Builds 3x3 sliding windows over a streamed input feature map, for CH channels in parallel.
- Sits directly upstream of the systolic input-skew stage. Its out_window bus has the same layout that stage consumes: per channel, 9 bytes = 72 bits; CH channels side by side.
- Holds two line buffers per channel plus a 3x3 window register. No padding, stride 1.

Parameters:
- CH, 18, number of parallel channels.
- DATA_WIDTH, 8, bits per pixel per channel.
- MAX_WIDTH, 64, maximum image width in pixels; sets line-buffer depth.
- DIM_W, 7, width of the cfg_width, cfg_height and internal row/col counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_width  in  DIM_W  image width; sampled on accepted in_sof.
- cfg_height  in  DIM_W  image height; sampled on accepted in_sof.
- in_valid  in  1  pixel valid; no backpressure, every valid pixel is accepted.
- in_sof  in  1  first pixel of a frame; qualified by in_valid.
- in_pixel  in  CH*DATA_WIDTH  one pixel, all channels; channel i at [8i +: 8].
- out_valid  out  1  out_window holds a complete window.
- out_last  out  1  with out_valid: last window of the frame.
- out_window  out  CH*9*DATA_WIDTH  channel i byte k at [72i + 8k +: 8].
- frame_done  out  1  one-cycle pulse, same cycle as out_last.
- cfg_err  out  1  sticky; set when a frame is rejected for bad dimensions.

Behaviour:
- Reset: out_valid=0, out_last=0, frame_done=0, cfg_err=0, out_window=0, window regs=0, row=col=0, state=IDLE. Line-buffer contents need not be reset.
- Window byte order: byte k = 3r+c. r=0 is the top (oldest) row, c=0 the left (oldest) column. Byte 8 is the newest pixel.
- FSM states: IDLE, RUN.
- IDLE:
  - in_valid without in_sof is ignored.
  - in_valid&in_sof: if 3<=cfg_width<=MAX_WIDTH and cfg_height>=3, latch W/H, process the pixel at (row 0, col 0), go to RUN.
  - Otherwise set cfg_err and stay in IDLE.
- RUN: each in_valid pixel is processed, then col increments. At col==W-1, col wraps to 0 and row increments.
- RUN, last pixel: the pixel at (H-1, W-1) is processed, then the block returns to IDLE.
- in_sof mid-frame (RUN, in_valid&in_sof): abandon the current frame and restart as in IDLE. An invalid config goes to IDLE and sets cfg_err. Any window for that pixel is not emitted from the old frame.
- Per accepted pixel, for each channel, all within one clock edge:
  - top = lb1[col], mid = lb0[col], read before write.
  - lb1[col] <= mid; lb0[col] <= pixel.
  - Window columns shift left: c0 <= c1, c1 <= c2, c2 <= {top, mid, pixel}.
- Output timing:
  - out_valid <= accepted && row>=2 && col>=2 (pre-increment row/col), registered.
  - Latency: 1 cycle from accepted pixel to window.
  - out_window reflects the window regs. It updates only on accepted pixels and holds otherwise.
- out_last and frame_done <= accepted && row==H-1 && col==W-1.
- Windows per frame: (W-2)*(H-2). Row-straddling windows (col<2) and stale line-buffer data (row<2) are never flagged valid.
- Idle cycles (in_valid=0) between pixels are legal anywhere. State and window are held, and out_valid drops to 0.
- Reset mid-frame: immediate return to reset values; the next frame must start with in_sof.

Test Plan:
- W=4,H=3, channel i pixel = 16r+c+i, contiguous valid:
  - exactly 2 out_valid pulses, on the cycles after pixels (2,2) and (2,3);
  - first window ch0 bytes 0..8 = 00,01,02,10,11,12,20,21,22; ch17 byte0=0x11;
  - second window has out_last=1 and frame_done=1, ch0 byte8=0x23.
- Same frame with in_valid toggled 1/0 every cycle -> identical window contents and count. out_valid is never high on an idle-following cycle without a new accepted pixel.
- W=MAX_WIDTH=64,H=4 -> 124 windows. Window (row 3, col 63) ch0 byte0 = pixel(1,61). Confirms line-buffer depth and wrap.
- cfg_width=2 with in_sof -> cfg_err=1, no out_valid. A following valid frame (W=3,H=3) yields 1 window, and cfg_err stays 1.
- in_sof reasserted at pixel (2,1) of a W=4,H=4 frame -> the old frame emits no further windows. The new frame produces 4 windows with correct contents.
- rstn pulsed low at pixel (2,2) -> outputs go to 0 asynchronously. Pixels without in_sof afterward produce no out_valid.
